// File: rtl/brick_collision.sv
// Brick-wall collision responder: tests ball top/bottom edge points against a brick grid.
// Optional macro BRICK_SCORE_EN enables the destroyed-brick score counter.
module brick_collision #(
  parameter int unsigned BRICK_COLS   = 8,
  parameter int unsigned BRICK_ROWS   = 4,
  parameter int unsigned BRICK_W_LOG2 = 7,
  parameter int unsigned BRICK_H_LOG2 = 5,
  parameter int unsigned GRID_LEFT    = 0,
  parameter int unsigned GRID_TOP     = 64,
  parameter int unsigned BALL_R       = 10
) (
  input  logic                             pclk,
  input  logic                             reset,
  input  logic [11:0]                      x_pos,
  input  logic [11:0]                      y_pos,
  input  logic                             new_game,
  output logic                             collision_det,
  output logic [BRICK_ROWS*BRICK_COLS-1:0] brick_map,
  output logic [15:0]                      score,
  output logic                             all_clear
);

  localparam int unsigned NumBricks  = BRICK_ROWS * BRICK_COLS;
  localparam int unsigned IdxW       = (NumBricks > 1) ? $clog2(NumBricks) : 1;
  localparam int unsigned GridWidth  = BRICK_COLS << BRICK_W_LOG2;
  localparam int unsigned GridHeight = BRICK_ROWS << BRICK_H_LOG2;

  typedef enum logic [1:0] {StIdle, StCheckTop, StCheckBot} state_e;

  state_e               state_q, state_d;
  logic [11:0]          px_l, py_l, px_d, py_d;
  logic                 coll_q, coll_d;
  logic [NumBricks-1:0] map_q, map_d;

  logic [31:0]          pt_x, pt_y, dx, dy;
  logic                 pt_valid, in_grid, hit, take;
  logic [IdxW-1:0]      idx;

  // Test point follows the check state; the top point is dropped when it would wrap above y=0.
  always_comb begin
    pt_x = {20'd0, px_l};
    if (state_q == StCheckBot) begin
      pt_y     = {20'd0, py_l} + BALL_R;
      pt_valid = 1'b1;
    end else begin
      pt_y     = {20'd0, py_l} - BALL_R;
      pt_valid = ({20'd0, py_l} >= BALL_R);
    end
    // Unsigned offsets wrap to huge values left/above the grid, so one compare bounds each axis.
    dx      = pt_x - GRID_LEFT;
    dy      = pt_y - GRID_TOP;
    in_grid = pt_valid && (dx < GridWidth) && (dy < GridHeight);
    idx     = IdxW'((dy >> BRICK_H_LOG2) * BRICK_COLS + (dx >> BRICK_W_LOG2));
    hit     = in_grid && map_q[idx];
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_l;
    py_d    = py_l;
    coll_d  = coll_q;
    map_d   = map_q;
    take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ({x_pos, y_pos} != {px_l, py_l}) begin
          px_d    = x_pos;
          py_d    = y_pos;
          coll_d  = 1'b0;
          state_d = StCheckTop;
        end
      end
      StCheckTop: begin
        if (hit) begin
          take    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StCheckBot;
        end
      end
      StCheckBot: begin
        take    = hit;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      map_d[idx] = 1'b0;
      coll_d     = 1'b1;
    end

    // Latched position is deliberately kept across a new game.
    if (new_game) begin
      state_d = StIdle;
      px_d    = px_l;
      py_d    = py_l;
      coll_d  = 1'b0;
      map_d   = '1;
      take    = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      px_l    <= 12'd0;
      py_l    <= 12'd0;
      coll_q  <= 1'b0;
      map_q   <= '1;
    end else begin
      state_q <= state_d;
      px_l    <= px_d;
      py_l    <= py_d;
      coll_q  <= coll_d;
      map_q   <= map_d;
    end
  end

`ifdef BRICK_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      score_q <= 16'd0;
    end else if (new_game) begin
      score_q <= 16'd0;
    end else if (take && (score_q != 16'hFFFF)) begin
      score_q <= score_q + 16'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

  assign collision_det = coll_q;
  assign brick_map     = map_q;
  assign all_clear     = ~|map_q;

endmodule

// File: doc/brick_collision.md
# brick_collision

Brick-wall collision responder for the ball game. It watches the ball centre (`x_pos`, `y_pos`) produced by the ball motion controllers and tests the ball's top and bottom edge points against a grid of bricks. On a hit it removes that brick and raises `collision_det`, which the vertical motion controller consumes to reverse direction. It also exports the live brick bitmap for the renderer, plus a score and an all-clear flag.

## Interface
Parameters:
- `BRICK_COLS`, default 8: bricks per row.
- `BRICK_ROWS`, default 4: brick rows.
- `BRICK_W_LOG2`, default 7: brick width is 2^n px (128).
- `BRICK_H_LOG2`, default 5: brick height is 2^n px (32).
- `GRID_LEFT`, default 0: grid left edge x.
- `GRID_TOP`, default 64: grid top edge y.
- `BALL_R`, default 10: ball radius in px.

Ports:
- `pclk`, in, 1: pixel clock. The block uses this single clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `x_pos`, in, 12: ball centre x.
- `y_pos`, in, 12: ball centre y.
- `new_game`, in, 1: synchronous pulse that restores all bricks.
- `collision_det`, out, 1: brick-hit flag. It is a level and stays high until the ball position changes.
- `brick_map`, out, `BRICK_ROWS*BRICK_COLS`: brick present bits. Bit index is `row*BRICK_COLS+col`.
- `score`, out, 16: count of bricks destroyed.
- `all_clear`, out, 1: combinational `~|brick_map`.

## Operation
- Reset values:
  - `brick_map` all ones.
  - `collision_det`=0, `score`=0.
  - State IDLE.
  - Latched position `px_l`/`py_l`=0.
- State machine: IDLE, CHECK_TOP, CHECK_BOT.
- IDLE:
  - If `{x_pos,y_pos}` != `{px_l,py_l}`: latch the inputs, clear `collision_det`, go to CHECK_TOP.
  - Otherwise hold.
- CHECK_TOP:
  - Test point is (`px_l`, `py_l-BALL_R`).
  - If `py_l<BALL_R`, the point is a miss. There is no wrap-around.
  - On a hit: clear the brick bit, set `collision_det`, increment `score`, go to IDLE.
  - On a miss: go to CHECK_BOT.
- CHECK_BOT:
  - Test point is (`px_l`, `py_l+BALL_R`), computed 13-bit with no overflow.
  - On a hit: same actions as a CHECK_TOP hit.
  - Then go to IDLE.
- Hit test for a point (px, py):
  - The point must be inside the grid: `GRID_LEFT`<=px<`GRID_LEFT+(BRICK_COLS<<BRICK_W_LOG2)`, and likewise for py against `GRID_TOP` and rows.
  - `col=(px-GRID_LEFT)>>BRICK_W_LOG2`, `row=(py-GRID_TOP)>>BRICK_H_LOG2`.
  - The addressed `brick_map` bit must be 1.
- At most one brick is removed per position change. The top point has priority.
- Input changes during CHECK_TOP/CHECK_BOT are ignored. They are detected on return to IDLE, because the inputs still differ from the latched values.
- `new_game`:
  - Overrides everything in any state: `brick_map` all ones, `score`=0, `collision_det`=0, state IDLE.
  - The latched position is kept.
- `score` saturates at 16'hFFFF.

## Timing
- Position change visible before edge N:
  - IDLE latches at N.
  - A top hit shows `collision_det`=1 and the updated `brick_map`/`score` after N+1.
  - A bottom hit shows them after N+2.
  - Back in IDLE after N+1 (top hit) or N+2.
- `collision_det` holds high from the hit until the edge where IDLE detects the next change, then falls after that edge.
  - The consumer samples only on its motion tick, so the level must persist. It does.
- `all_clear` follows `brick_map` combinationally. It is high in the same cycle the last bit clears.
- Reset asserted mid-check: all outputs return to reset values immediately, with no clock needed. The pending check is dropped.
- `new_game` coincident with a hit: `new_game` wins. The bricks are restored and no `collision_det` is raised.

## Configuration
- `BRICK_SCORE_EN`:
  - Defined: `score` counter is present as described.
  - Undefined: `score` is tied to 16'd0, with no counter logic. `brick_map`, `collision_det` and `all_clear` are unchanged.

## Test plan
- Reset, then x=300, y=400 -> `brick_map`=32'hFFFF_FFFF, `collision_det` stays 0, `score`=0.
- x=300, y=200 -> top point 190 hits row 3 col 2 (bit 26). After 2 edges: bit 26=0, `collision_det`=1, `score`=1. Hold y=200 -> stays 1. Step to y=201 -> drops, no new hit.
- x=50, y=54 -> top point 44 misses, bottom point 64 hits bit 0 after 3 edges. x=50, y=5 -> top point skipped (no wrap), bottom point 15 misses, `collision_det`=0.
- Sweep hits over all 32 bricks -> `score`=32 and `all_clear`=1 in the cycle bit clears. Then `new_game` pulse -> all ones, `score`=0, `all_clear`=0.
- Assert `reset` during CHECK_BOT of a would-be hit -> brick untouched, `collision_det`=0, state IDLE.
- Build without `BRICK_SCORE_EN`, repeat the hit scenario -> `brick_map` updates, `score` stays 0.
